rv32i_instr_encoder: RTL and testbench
======================================

// Module: rv32i_instr_encoder
// PURPOSE
//  Streaming RV32I assembler back-end, the inverse of the CPU decode stage. Accepts one
//  (mnemonic, rd, rs1, rs2, imm) request per valid/ready handshake. Emits the 32-bit
//  encoded word plus a sequential word address to the instruction-memory loader/test harness.
//  A start/last-framed run FSM drives it. One output register stage, full throughput.
// PARAMETERS
//  ADDR_W     32           width of out_addr; address wraps modulo 2**ADDR_W
//  BASE_ADDR  32'h0000_0000 address of first word of every run (word aligned)
// PORTS
//  clk          in   1   clock; all state on rising edge
//  rstn         in   1   reset, asynchronous assert, active low
//  start        in   1   pulse: begin a run (honoured only in IDLE)
//  in_valid     in   1   request valid
//  in_ready     out  1   request accepted when in_valid & in_ready
//  in_mnem      in   6   mnemonic code: 0 lui,1 auipc,2 addi,3 slti,4 sltiu,5 xori,6 ori,7 andi,
//                        8 slli,9 srli,10 srai,11 add,12 sub,13 sll,14 slt,15 sltu,16 xor,17 srl,
//                        18 sra,19 or,20 and,21 jal,22 jalr,23 beq,24 bne,25 blt,26 bge,27 bltu,
//                        28 bgeu,29 lb,30 lh,31 lw,32 lbu,33 lhu,34 sb,35 sh,36 sw; 37..63 illegal
//  in_rd/in_rs1/in_rs2 in 5 each  register fields (ignored where format lacks them)
//  in_imm       in   32  architectural immediate: U uses [31:12]; shifts use [4:0] as shamt;
//                        I/S signed 12b; B signed 13b byte offset; J signed 21b byte offset
//  in_last      in   1   final request of the run
//  out_valid    out  1   encoded word valid
//  out_ready    in   1   consumer accepts when out_valid & out_ready
//  out_instr    out  32  encoded instruction
//  out_addr     out  ADDR_W  word address
//  done         out  1   one-cycle pulse after the last word's output handshake
//  err_illegal  out  1   sticky: an illegal mnemonic was received this run
//  word_cnt     out  16  words emitted this run (saturates at 16'hFFFF)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, done, err_illegal = 0; out_instr = 0;
//   out_addr = BASE_ADDR; word_cnt = 0.
//  FSM: IDLE -start-> RUN (clear err flags and word_cnt, out_addr=BASE_ADDR).
//   RUN -accept with in_last-> DRAIN. DRAIN -output handshake of last word-> DONE.
//   DONE -> IDLE after 1 cycle (done=1 only in DONE). start outside IDLE: ignored.
//  in_ready = (state==RUN) & (~out_valid | out_ready). in_ready is 0 in IDLE/DRAIN/DONE.
//  Latency 1: request accepted at edge N gives out_valid=1 with the word after edge N.
//   Back-to-back accept/emit sustains 1 word/cycle. out_* hold stable while out_valid & ~out_ready.
//  out_addr: increments by 4 after each output handshake; wraps modulo 2**ADDR_W.
//   word_cnt increments at the same edge.
//  Encoding: standard RV32I fields. Opcodes 37/17/13/33/6F/67/63/03/23. funct7[5]=1 for
//   sub, sra and srai (srai imm[11:5]=7'b0100000). B/J drop imm[0].
//  Illegal mnemonic: request accepted, nothing emitted, err_illegal set; in_last still ends run
//   (done fires; if nothing pending, DRAIN exits next cycle).
//  Simultaneous accept+emit in same cycle is legal and expected. rstn low mid-run aborts
//   immediately to reset values. Pending word is lost.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined: a request is out of range when any of these holds:
//   immediate not representable in its format (I/S outside -2048..2047; B outside -4096..4094
//   or odd; J outside +-1MiB or odd; U with imm[11:0]!=0; shamt with imm[31:5]!=0).
//   Such a request is dropped like an illegal one and sets extra sticky output
//   err_range (1 bit, reset 0, cleared on start).
//  Not defined: no err_range port; out-of-range immediates are silently truncated to their fields.
// TESTING
//  start; addi rd=1,rs1=2,imm=-1 -> out_instr=32'hFFF10093 at out_addr=0, word_cnt=1
//  sub rd=3,rs1=4,rs2=5 then beq rs1=1,rs2=2,imm=8 -> 32'h405201B3 @0, 32'h00208463 @4
//  lui rd=5,imm=32'h12345000; jal rd=1,imm=2048; sw rs1=7,rs2=6,imm=12 (last)
//   -> 32'h123452B7, 32'h001000EF, 32'h0063A623 @0,4,8; done pulses once; state back to IDLE
//  out_ready held 0 for 5 cycles with 2 requests queued -> in_ready=0, out_* stable, no word lost
//  in_mnem=40 mid-run -> no output, err_illegal=1 until next start; subsequent addresses contiguous
//  IMM_RANGE_CHECK_EN: addi imm=4096 -> dropped, err_range=1. Without it: word 32'h00000013 emitted

Source files
------------

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I instruction encoder: one request per handshake in, one encoded
// word plus sequential word address out, framed by a start/last run FSM.
// Optional build macro IMM_RANGE_CHECK_EN: drop requests whose immediate does not
// fit its format and report them on the sticky err_range output.
module rv32i_instr_encoder #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_mnem,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err_illegal,
`ifdef IMM_RANGE_CHECK_EN
    output logic              err_range,
`endif
    output logic [15:0]       word_cnt
);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef enum logic [2:0] {FMT_U, FMT_I, FMT_SH, FMT_R, FMT_S, FMT_B, FMT_J} fmt_t;

    state_t      state_q, state_d;
    fmt_t        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic        drop;
    logic [31:0] enc;
    logic        accept;
    logic        out_hs;
    logic        run_start;
`ifdef IMM_RANGE_CHECK_EN
    logic        range_err;
    logic        fits12, fits13, fits21;
`endif

    // Mnemonic to format, opcode and function fields
    always_comb begin
        fmt   = FMT_R;
        opc   = OP_REG;
        f3    = 3'd0;
        f7    = 7'd0;
        legal = 1'b1;
        case (in_mnem)
            6'd0:  begin fmt = FMT_U;  opc = OP_LUI;   end
            6'd1:  begin fmt = FMT_U;  opc = OP_AUIPC; end
            6'd2:  begin fmt = FMT_I;  opc = OP_IMM; f3 = 3'd0; end
            6'd3:  begin fmt = FMT_I;  opc = OP_IMM; f3 = 3'd2; end
            6'd4:  begin fmt = FMT_I;  opc = OP_IMM; f3 = 3'd3; end
            6'd5:  begin fmt = FMT_I;  opc = OP_IMM; f3 = 3'd4; end
            6'd6:  begin fmt = FMT_I;  opc = OP_IMM; f3 = 3'd6; end
            6'd7:  begin fmt = FMT_I;  opc = OP_IMM; f3 = 3'd7; end
            6'd8:  begin fmt = FMT_SH; opc = OP_IMM; f3 = 3'd1; end
            6'd9:  begin fmt = FMT_SH; opc = OP_IMM; f3 = 3'd5; end
            6'd10: begin fmt = FMT_SH; opc = OP_IMM; f3 = 3'd5; f7 = F7_ALT; end
            6'd11: begin f3 = 3'd0; end
            6'd12: begin f3 = 3'd0; f7 = F7_ALT; end
            6'd13: begin f3 = 3'd1; end
            6'd14: begin f3 = 3'd2; end
            6'd15: begin f3 = 3'd3; end
            6'd16: begin f3 = 3'd4; end
            6'd17: begin f3 = 3'd5; end
            6'd18: begin f3 = 3'd5; f7 = F7_ALT; end
            6'd19: begin f3 = 3'd6; end
            6'd20: begin f3 = 3'd7; end
            6'd21: begin fmt = FMT_J;  opc = OP_JAL;  end
            6'd22: begin fmt = FMT_I;  opc = OP_JALR; f3 = 3'd0; end
            6'd23: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'd0; end
            6'd24: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'd1; end
            6'd25: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'd4; end
            6'd26: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'd5; end
            6'd27: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'd6; end
            6'd28: begin fmt = FMT_B;  opc = OP_BRANCH; f3 = 3'd7; end
            6'd29: begin fmt = FMT_I;  opc = OP_LOAD;  f3 = 3'd0; end
            6'd30: begin fmt = FMT_I;  opc = OP_LOAD;  f3 = 3'd1; end
            6'd31: begin fmt = FMT_I;  opc = OP_LOAD;  f3 = 3'd2; end
            6'd32: begin fmt = FMT_I;  opc = OP_LOAD;  f3 = 3'd4; end
            6'd33: begin fmt = FMT_I;  opc = OP_LOAD;  f3 = 3'd5; end
            6'd34: begin fmt = FMT_S;  opc = OP_STORE; f3 = 3'd0; end
            6'd35: begin fmt = FMT_S;  opc = OP_STORE; f3 = 3'd1; end
            6'd36: begin fmt = FMT_S;  opc = OP_STORE; f3 = 3'd2; end
            default: legal = 1'b0;
        endcase
    end

    // Field packing per instruction format
    always_comb begin
        enc = 32'd0;
        case (fmt)
            FMT_U:  enc = {in_imm[31:12], in_rd, opc};
            FMT_I:  enc = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            FMT_SH: enc = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
            FMT_R:  enc = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            FMT_S:  enc = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            FMT_B:  enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                           in_imm[4:1], in_imm[11], opc};
            FMT_J:  enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
            default: enc = 32'd0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate representability in the selected format
    always_comb begin
        fits12    = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        fits13    = (&in_imm[31:12]) | ~(|in_imm[31:12]);
        fits21    = (&in_imm[31:20]) | ~(|in_imm[31:20]);
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = ~fits12;
            FMT_B:        range_err = ~fits13 | in_imm[0];
            FMT_J:        range_err = ~fits21 | in_imm[0];
            FMT_U:        range_err = |in_imm[11:0];
            FMT_SH:       range_err = |in_imm[31:5];
            default:      range_err = 1'b0;
        endcase
        drop = ~legal | range_err;
    end
`else
    // Only unknown mnemonics are dropped; immediates are truncated to their fields
    always_comb drop = ~legal;
`endif

    // Run FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Run FSM next state and handshake decode
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == RUN) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        run_start = (state_q == IDLE) && start;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && in_last) state_d = DRAIN;
            DRAIN:   if (!out_valid || out_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output word register, address/count tracking and sticky error flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            out_instr   <= 32'd0;
            out_addr    <= BASE_ADDR;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            word_cnt    <= 16'd0;
`ifdef IMM_RANGE_CHECK_EN
            err_range   <= 1'b0;
`endif
        end else begin
            done <= (state_d == DONE);
            if (accept && !drop) begin
                out_valid <= 1'b1;
                out_instr <= enc;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (run_start) begin
                out_addr    <= BASE_ADDR;
                word_cnt    <= 16'd0;
                err_illegal <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
                err_range   <= 1'b0;
`endif
            end else begin
                if (out_hs) begin
                    out_addr <= out_addr + ADDR_W'(4);
                    if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
                end
                if (accept && !legal) err_illegal <= 1'b1;
`ifdef IMM_RANGE_CHECK_EN
                if (accept && legal && range_err) err_range <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed bench for rv32i_instr_encoder: encoding table plus framing,
// backpressure, illegal-mnemonic, immediate-range and reset corner cases.
module tb_rv32i_instr_encoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_mnem;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        done;
    logic        err_illegal;
    logic [15:0] word_cnt;
`ifdef IMM_RANGE_CHECK_EN
    logic        err_range;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  mnem;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    rv32i_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .done(done),
        .err_illegal(err_illegal),
`ifdef IMM_RANGE_CHECK_EN
        .err_range(err_range),
`endif
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Present one request and return #1 after the edge that accepted it
    task automatic do_req(input logic [5:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        int n;
        @(negedge clk);
        in_mnem = m; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // After the final accept: done one cycle later, then back to IDLE
    task automatic expect_done(input string name, input logic [15:0] cnt);
        @(posedge clk); #1;
        chk1({name, "_done"}, done, 1'b1);
        chk({name, "_cnt"}, 32'(word_cnt), 32'(cnt));
        @(posedge clk); #1;
        chk1({name, "_done_clr"}, done, 1'b0);
        chk1({name, "_idle_rdy"}, in_ready, 1'b0);
    endtask

    function automatic vec_t mk(input logic [5:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] e);
        vec_t v;
        v.mnem = m; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = e;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_addr;
        logic [31:0] held_instr;

        vecs[0]  = mk(6'd2,  5'd1,  5'd2,  5'd0,  32'hFFFF_FFFF, 32'hFFF10093); // addi
        vecs[1]  = mk(6'd12, 5'd3,  5'd4,  5'd5,  32'h0,         32'h405201B3); // sub
        vecs[2]  = mk(6'd23, 5'd0,  5'd1,  5'd2,  32'd8,         32'h00208463); // beq
        vecs[3]  = mk(6'd0,  5'd5,  5'd0,  5'd0,  32'h12345000,  32'h123452B7); // lui
        vecs[4]  = mk(6'd21, 5'd1,  5'd0,  5'd0,  32'd2048,      32'h001000EF); // jal
        vecs[5]  = mk(6'd36, 5'd0,  5'd7,  5'd6,  32'd12,        32'h0063A623); // sw
        vecs[6]  = mk(6'd10, 5'd10, 5'd11, 5'd0,  32'd3,         32'h4035D513); // srai
        vecs[7]  = mk(6'd1,  5'd2,  5'd0,  5'd0,  32'hABCDE000,  32'hABCDE117); // auipc
        vecs[8]  = mk(6'd22, 5'd1,  5'd5,  5'd0,  32'd4,         32'h004280E7); // jalr
        vecs[9]  = mk(6'd31, 5'd8,  5'd2,  5'd0,  32'hFFFF_FFFC, 32'hFFC12403); // lw
        vecs[10] = mk(6'd24, 5'd0,  5'd3,  5'd4,  32'hFFFF_FFF8, 32'hFE419CE3); // bne -8
        vecs[11] = mk(6'd18, 5'd6,  5'd7,  5'd8,  32'h0,         32'h4083D333); // sra
        vecs[12] = mk(6'd4,  5'd9,  5'd10, 5'd0,  32'd1,         32'h00153493); // sltiu
        vecs[13] = mk(6'd21, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFC, 32'hFFDFF06F); // jal -4
        vecs[14] = mk(6'd35, 5'd0,  5'd2,  5'd3,  32'hFFFF_FFFE, 32'hFE311F23); // sh -2
        vecs[15] = mk(6'd8,  5'd1,  5'd1,  5'd0,  32'd31,        32'h01F09093); // slli 31
        vecs[16] = mk(6'd20, 5'd1,  5'd2,  5'd3,  32'h0,         32'h003170B3); // and
        vecs[17] = mk(6'd32, 5'd4,  5'd5,  5'd0,  32'h0,         32'h0002C203); // lbu
        vecs[18] = mk(6'd28, 5'd0,  5'd1,  5'd2,  32'd4094,      32'h7E20FFE3); // bgeu max

        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_mnem = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err_illegal", err_illegal, 1'b0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_word_cnt", 32'(word_cnt), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Encoding table, one run, contiguous addresses
        pulse_start();
        chk1("run_in_ready", in_ready, 1'b1);
        exp_addr = 0;
        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].mnem, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, i == NV - 1);
            chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), out_addr, 32'(exp_addr));
            exp_addr += 4;
        end
        expect_done("table", 16'(NV));
        chk("table_end_addr", out_addr, 32'(exp_addr));

        // Backpressure: word held while a second request waits
        pulse_start();
        chk("bp_addr_reset", out_addr, 32'h0);
        out_ready = 1'b0;
        do_req(vecs[0].mnem, vecs[0].rd, vecs[0].rs1, vecs[0].rs2, vecs[0].imm, 1'b0);
        chk("bp_first", out_instr, vecs[0].exp);
        held_instr = out_instr;
        @(negedge clk);
        in_mnem = vecs[1].mnem; in_rd = vecs[1].rd; in_rs1 = vecs[1].rs1;
        in_rs2 = vecs[1].rs2; in_imm = vecs[1].imm; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk1($sformatf("bp_stall%0d_rdy", c), in_ready, 1'b0);
            chk1($sformatf("bp_stall%0d_valid", c), out_valid, 1'b1);
            chk($sformatf("bp_stall%0d_instr", c), out_instr, held_instr);
            chk($sformatf("bp_stall%0d_addr", c), out_addr, 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk1("bp_release_rdy", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_second", out_instr, vecs[1].exp);
        chk("bp_second_addr", out_addr, 32'h4);
        chk("bp_cnt_mid", 32'(word_cnt), 32'd1);
        expect_done("bp", 16'd2);

        // Illegal mnemonic mid-run, ignored start, contiguous addressing
        pulse_start();
        do_req(vecs[0].mnem, vecs[0].rd, vecs[0].rs1, vecs[0].rs2, vecs[0].imm, 1'b0);
        chk("ill_first_addr", out_addr, 32'h0);
        do_req(6'd40, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0);
        chk1("ill_no_out", out_valid, 1'b0);
        chk1("ill_flag", err_illegal, 1'b1);
        pulse_start();
        chk1("ill_start_ignored", err_illegal, 1'b1);
        do_req(vecs[3].mnem, vecs[3].rd, vecs[3].rs1, vecs[3].rs2, vecs[3].imm, 1'b1);
        chk("ill_next_instr", out_instr, vecs[3].exp);
        chk("ill_next_addr", out_addr, 32'h4);
        expect_done("ill", 16'd2);
        chk1("ill_sticky_idle", err_illegal, 1'b1);
        pulse_start();
        chk1("ill_cleared", err_illegal, 1'b0);

        // Illegal mnemonic as the last request still ends the run
        do_req(6'd63, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        chk1("ill_last_no_out", out_valid, 1'b0);
        chk1("ill_last_flag", err_illegal, 1'b1);
        expect_done("ill_last", 16'd0);

        // Out-of-range addi immediate
        pulse_start();
        do_req(6'd2, 5'd0, 5'd0, 5'd0, 32'd4096, 1'b1);
`ifdef IMM_RANGE_CHECK_EN
        chk1("rng_dropped", out_valid, 1'b0);
        chk1("rng_flag", err_range, 1'b1);
        expect_done("rng", 16'd0);
`else
        chk1("rng_valid", out_valid, 1'b1);
        chk("rng_trunc", out_instr, 32'h00000013);
        expect_done("rng", 16'd1);
`endif

        // Reset mid-run discards the pending word
        pulse_start();
        out_ready = 1'b0;
        do_req(vecs[2].mnem, vecs[2].rd, vecs[2].rs1, vecs[2].rs2, vecs[2].imm, 1'b0);
        chk1("mrst_pending", out_valid, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk1("mrst_valid", out_valid, 1'b0);
        chk("mrst_instr", out_instr, 32'h0);
        chk1("mrst_rdy", in_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk1("mrst_idle_rdy", in_ready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
